// File: rtl/fp_arr_serializer_pkg.sv
// Shared types and mode constants for the fixed-point array serializer.
package fp_ser_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Rounding modes applied when fractional bits are dropped
  localparam int RND_TRUNC   = 0;  // floor (toward -inf)
  localparam int RND_HALF_UP = 1;  // add half an output LSB, then floor

  // Overflow handling when the result leaves the output range
  localparam int OVF_WRAP = 0;     // keep low bits
  localparam int OVF_SAT  = 1;     // clamp to the output range

endpackage

// File: rtl/fp_arr_serializer_if.sv
// Fixed-point scalar (sfp) and array (sfp_arr) buses. The dummy_* members
// carry the format in their widths so consumers can derive it with $bits:
//   $bits(dummy_wl) = word length, $bits(dummy_qw) = fraction bits,
//   $bits(dummy_signed) - 1 = signedness.
interface sfp #(
  parameter int WL  = 8,
  parameter int QW  = 4,
  parameter int SGN = 1
);
  logic [WL-1:0]  val;
  logic [WL-1:0]  dummy_wl;
  logic [QW-1:0]  dummy_qw;
  logic [SGN:0]   dummy_signed;

  assign dummy_wl     = '0;
  assign dummy_qw     = '0;
  assign dummy_signed = '0;

  modport in  (input  val, input dummy_wl, input dummy_qw, input dummy_signed);
  modport out (output val, input dummy_wl, input dummy_qw, input dummy_signed);
endinterface

interface sfp_arr #(
  parameter int SIZE = 4,
  parameter int WL   = 8,
  parameter int QW   = 4,
  parameter int SGN  = 1
);
  logic [SIZE-1:0][WL-1:0] val;
  logic [WL-1:0]           dummy_wl;
  logic [QW-1:0]           dummy_qw;
  logic [SGN:0]            dummy_signed;

  assign dummy_wl     = '0;
  assign dummy_qw     = '0;
  assign dummy_signed = '0;

  modport in  (input  val, input dummy_wl, input dummy_qw, input dummy_signed);
  modport out (output val, input dummy_wl, input dummy_qw, input dummy_signed);
endinterface

// File: rtl/fp_requant.sv
// Combinational fixed-point requantizer: realigns the binary point from
// IN_QW to OUT_QW fraction bits, with optional half-up rounding and
// saturation. Saturation is evaluated after rounding so max+0.5 clamps.
module fp_requant
  import fp_ser_pkg::*;
#(
  parameter int IN_QW  = 4,
  parameter int IN_WL  = 8,
  parameter int OUT_QW = 2,
  parameter int OUT_WL = 5,
  parameter int SGN    = 1,
  parameter int ROUND  = RND_HALF_UP,
  parameter int SAT    = OVF_SAT
) (
  input  logic [IN_WL-1:0]  din,
  output logic [OUT_WL-1:0] dout
);
  localparam int S  = IN_QW - OUT_QW;
  localparam int AS = (S < 0) ? -S : S;
  localparam int SR = (S > 0) ? S : 1;  // keeps the unused shift amount legal
  localparam int XW = IN_WL + AS + 1;
  // One extra bit so unsigned values and both range limits stay representable
  // as positive/negative signed numbers.
  localparam int W  = ((XW > OUT_WL) ? XW : OUT_WL) + 1;

  localparam logic signed [W-1:0] ONE  = 1;
  localparam logic signed [W-1:0] HALF = ONE <<< (SR - 1);
  localparam logic signed [W-1:0] MAXV = (SGN != 0) ? (ONE <<< (OUT_WL - 1)) - ONE
                                                    : (ONE <<< OUT_WL) - ONE;
  localparam logic signed [W-1:0] MINV = (SGN != 0) ? -(ONE <<< (OUT_WL - 1))
                                                    : {W{1'b0}};

  logic                ext;
  logic signed [W-1:0] x;
  logic signed [W-1:0] r;
  logic signed [W-1:0] y;

  // Extend, round, shift, then range-limit
  always_comb begin
    ext = (SGN != 0) ? din[IN_WL-1] : 1'b0;
    x   = {{(W - IN_WL){ext}}, din};
    r   = x;
    y   = x;
    if (S > 0) begin
      if (ROUND == RND_HALF_UP) r = x + HALF;
      y = r >>> SR;
    end else begin
      y = x <<< AS;
    end
    dout = y[OUT_WL-1:0];
    if (SAT == OVF_SAT) begin
      if (y > MAXV)      dout = MAXV[OUT_WL-1:0];
      else if (y < MINV) dout = MINV[OUT_WL-1:0];
    end
  end

endmodule

// File: rtl/fp_arr_serializer.sv
// Array-to-stream serializer: captures a whole fixed-point array on accept
// and emits it one requantized element per beat, index 0 first. On the last
// beat the input is opened combinationally so arrays can flow back-to-back.
module fp_arr_serializer
  import fp_ser_pkg::*;
#(
  parameter int SIZE  = 4,
  parameter int ROUND = RND_HALF_UP,
  parameter int SAT   = OVF_SAT,
  localparam int IDXW = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic            clk,
  input  logic            rst,
  sfp_arr.in              din,
  input  logic            din_valid,
  output logic            din_ready,
  sfp.out                 dout,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic [IDXW-1:0] dout_idx,
  output logic            dout_last
);
  localparam int IN_WL   = $bits(din.dummy_wl);
  localparam int IN_QW   = $bits(din.dummy_qw);
  localparam int IN_SGN  = $bits(din.dummy_signed) - 1;
  localparam int OUT_WL  = $bits(dout.dummy_wl);
  localparam int OUT_QW  = $bits(dout.dummy_qw);
  localparam int OUT_SGN = $bits(dout.dummy_signed) - 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SIZE - 1);

  if (IN_SGN != OUT_SGN) begin : g_sgn_err
    $fatal(1, "fp_arr_serializer: din/dout signedness mismatch");
  end
  if ($bits(din.val) != SIZE * IN_WL) begin : g_size_err
    $fatal(1, "fp_arr_serializer: SIZE does not match din");
  end

  state_e                     state_q, state_d;
  logic [IDXW-1:0]            idx_q, idx_d;
  logic [SIZE-1:0][IN_WL-1:0] arr_q, arr_d;
  logic                       is_last;
  logic [OUT_WL-1:0]          rq;

  assign is_last    = (state_q == SEND) && (idx_q == LAST_IDX);
  assign dout_valid = (state_q == SEND);
  assign dout_last  = is_last;
  assign dout_idx   = idx_q;
  assign din_ready  = !rst && ((state_q == IDLE) || (is_last && dout_ready));
  assign dout.val   = dout_valid ? rq : '0;

  fp_requant #(
    .IN_QW (IN_QW),  .IN_WL (IN_WL),
    .OUT_QW(OUT_QW), .OUT_WL(OUT_WL),
    .SGN   (IN_SGN), .ROUND (ROUND), .SAT(SAT)
  ) u_rq (
    .din (arr_q[idx_q]),
    .dout(rq)
  );

  // Next state: capture on accept, advance on beat, reload or idle after last
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    arr_d   = arr_q;
    case (state_q)
      IDLE: begin
        if (din_valid && din_ready) begin
          arr_d   = din.val;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (dout_ready) begin
          if (!is_last) begin
            idx_d = idx_q + 1'b1;
          end else if (din_valid) begin
            arr_d = din.val;
            idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, index and element buffer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      arr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      arr_q   <= arr_d;
    end
  end

endmodule

// File: tb/tb_fp_arr_serializer.sv
// Directed bench: three serializers (SIZE 4 round/sat, SIZE 4 trunc/wrap,
// SIZE 1 round/sat), din s.4 in 8 bits, dout s.2 in 5 bits.
module tb_fp_arr_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sfp_arr #(.SIZE(4), .WL(8), .QW(4), .SGN(1)) a_in ();
  sfp_arr #(.SIZE(4), .WL(8), .QW(4), .SGN(1)) b_in ();
  sfp_arr #(.SIZE(1), .WL(8), .QW(4), .SGN(1)) c_in ();
  sfp #(.WL(5), .QW(2), .SGN(1)) a_out ();
  sfp #(.WL(5), .QW(2), .SGN(1)) b_out ();
  sfp #(.WL(5), .QW(2), .SGN(1)) c_out ();

  logic a_din_valid = 0, a_din_ready, a_dout_valid, a_dout_ready = 1, a_dout_last;
  logic b_din_valid = 0, b_din_ready, b_dout_valid, b_dout_ready = 1, b_dout_last;
  logic c_din_valid = 0, c_din_ready, c_dout_valid, c_dout_ready = 1, c_dout_last;
  logic [1:0] a_dout_idx, b_dout_idx;
  logic [0:0] c_dout_idx;

  fp_arr_serializer #(.SIZE(4), .ROUND(1), .SAT(1)) u_a (
    .clk(clk), .rst(rst), .din(a_in), .din_valid(a_din_valid), .din_ready(a_din_ready),
    .dout(a_out), .dout_valid(a_dout_valid), .dout_ready(a_dout_ready),
    .dout_idx(a_dout_idx), .dout_last(a_dout_last));
  fp_arr_serializer #(.SIZE(4), .ROUND(0), .SAT(0)) u_b (
    .clk(clk), .rst(rst), .din(b_in), .din_valid(b_din_valid), .din_ready(b_din_ready),
    .dout(b_out), .dout_valid(b_dout_valid), .dout_ready(b_dout_ready),
    .dout_idx(b_dout_idx), .dout_last(b_dout_last));
  fp_arr_serializer #(.SIZE(1), .ROUND(1), .SAT(1)) u_c (
    .clk(clk), .rst(rst), .din(c_in), .din_valid(c_din_valid), .din_ready(c_din_ready),
    .dout(c_out), .dout_valid(c_dout_valid), .dout_ready(c_dout_ready),
    .dout_idx(c_dout_idx), .dout_last(c_dout_last));

  // arrA[0] = 0x18 is element 0
  logic [3:0][7:0] arr_a = {8'h50, 8'hFE, 8'h26, 8'h18};
  logic [3:0][7:0] arr_b = {8'h7F, 8'h00, 8'h26, 8'h90};
  logic [4:0] exp_a  [4] = '{5'h06, 5'h0A, 5'h00, 5'h0F};
  logic [4:0] exp_b  [4] = '{5'h10, 5'h0A, 5'h00, 5'h0F};  // round + sat
  logic [4:0] exp_bw [4] = '{5'h04, 5'h09, 5'h00, 5'h1F};  // trunc + wrap
  logic [8:0] got, want;

  task automatic test_reset();
    #2;
    checks++;
    if ({a_din_ready, a_dout_valid, a_dout_last, a_out.val} !== 8'h00) begin
      errors++;
      $display("FAIL reset_a: got %h want 00", {a_din_ready, a_dout_valid, a_dout_last, a_out.val});
    end
    checks++;
    if ({c_din_ready, c_dout_valid, c_dout_last, c_out.val} !== 8'h00) begin
      errors++;
      $display("FAIL reset_c: got %h want 00", {c_din_ready, c_dout_valid, c_dout_last, c_out.val});
    end
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if ({a_din_ready, a_dout_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release: ready/valid got %b want 10", {a_din_ready, a_dout_valid});
    end
  endtask

  task automatic test_requant_order();
    @(negedge clk); a_in.val = arr_a; a_din_valid = 1; a_dout_ready = 1; #1;
    checks++;
    if ({a_din_ready, a_dout_valid} !== 2'b10) begin
      errors++;
      $display("FAIL order_accept: ready/valid got %b want 10", {a_din_ready, a_dout_valid});
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); a_din_valid = 0; a_in.val = 32'hDEADBEEF; #1;
      got  = {a_dout_valid, a_dout_idx, a_dout_last, a_out.val};
      want = {1'b1, 2'(k), (k == 3), exp_a[k]};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL order_beat%0d: v/idx/last/val got %h want %h", k, got, want);
      end
      checks++;
      if (a_din_ready !== (k == 3)) begin
        errors++;
        $display("FAIL order_ready%0d: got %b want %b", k, a_din_ready, (k == 3));
      end
    end
    @(negedge clk); #1;
    checks++;
    if ({a_dout_valid, a_din_ready} !== 2'b01) begin
      errors++;
      $display("FAIL order_idle: valid/ready got %b want 01", {a_dout_valid, a_din_ready});
    end
  endtask

  task automatic test_sat_wrap();
    @(negedge clk);
    a_in.val = arr_b; b_in.val = arr_b; a_din_valid = 1; b_din_valid = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); a_din_valid = 0; b_din_valid = 0; #1;
      checks++;
      if ({a_dout_valid, a_out.val} !== {1'b1, exp_b[k]}) begin
        errors++;
        $display("FAIL sat_beat%0d: got %h want %h", k, {a_dout_valid, a_out.val}, {1'b1, exp_b[k]});
      end
      got  = {b_dout_valid, b_dout_idx, b_dout_last, b_out.val};
      want = {1'b1, 2'(k), (k == 3), exp_bw[k]};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL wrap_beat%0d: got %h want %h", k, got, want);
      end
    end
    @(negedge clk); #1;
    checks++;
    if ({a_dout_valid, b_dout_valid} !== 2'b00) begin
      errors++;
      $display("FAIL sat_wrap_idle: got %b want 00", {a_dout_valid, b_dout_valid});
    end
  endtask

  task automatic test_backpressure();
    logic pat [12] = '{1, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0, 1};
    int   exp_k = 0;
    @(negedge clk); a_in.val = arr_a; a_din_valid = 1; a_dout_ready = 1;
    for (int c = 0; c < 12 && exp_k < 4; c++) begin
      @(negedge clk); a_din_valid = 0; a_dout_ready = pat[c]; #1;
      got  = {a_dout_valid, a_dout_idx, a_dout_last, a_out.val};
      want = {1'b1, 2'(exp_k), (exp_k == 3), exp_a[exp_k]};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL bp_cycle%0d: got %h want %h", c, got, want);
      end
      checks++;
      if (a_din_ready !== (exp_k == 3 && pat[c])) begin
        errors++;
        $display("FAIL bp_ready%0d: got %b want %b", c, a_din_ready, (exp_k == 3 && pat[c]));
      end
      if (pat[c]) exp_k++;
    end
    checks++;
    if (exp_k != 4) begin
      errors++;
      $display("FAIL bp_done: beats got %0d want 4", exp_k);
    end
    @(negedge clk); a_dout_ready = 1; #1;
    checks++;
    if (a_dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_idle: valid got %b want 0", a_dout_valid);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); a_in.val = arr_a; a_din_valid = 1; a_dout_ready = 1; #1;
    checks++;
    if (a_din_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: ready got %b want 1", a_din_ready);
    end
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      a_in.val = arr_b;
      a_din_valid = (j < 4);
      #1;
      got  = {a_dout_valid, a_dout_idx, a_dout_last, a_out.val};
      want = {1'b1, 2'(j % 4), (j % 4 == 3), (j < 4) ? exp_a[j % 4] : exp_b[j % 4]};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL b2b_beat%0d: got %h want %h", j, got, want);
      end
      checks++;
      if (a_din_ready !== (j % 4 == 3)) begin
        errors++;
        $display("FAIL b2b_ready%0d: got %b want %b", j, a_din_ready, (j % 4 == 3));
      end
    end
    @(negedge clk); #1;
    checks++;
    if (a_dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: valid got %b want 0", a_dout_valid);
    end
  endtask

  task automatic test_size1();
    logic [7:0] src [3] = '{8'h18, 8'h26, 8'h50};
    logic [4:0] ex  [3] = '{5'h06, 5'h0A, 5'h0F};
    @(negedge clk); c_in.val = src[0]; c_din_valid = 1; c_dout_ready = 1; #1;
    checks++;
    if (c_din_ready !== 1'b1) begin
      errors++;
      $display("FAIL s1_accept: ready got %b want 1", c_din_ready);
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      c_din_valid = (j < 2);
      if (j < 2) c_in.val = src[j + 1];
      #1;
      checks++;
      if ({c_dout_valid, c_dout_idx, c_dout_last, c_din_ready, c_out.val} !== {4'b1011, ex[j]}) begin
        errors++;
        $display("FAIL s1_beat%0d: got %h want %h", j,
                 {c_dout_valid, c_dout_idx, c_dout_last, c_din_ready, c_out.val}, {4'b1011, ex[j]});
      end
    end
    @(negedge clk); #1;
    checks++;
    if (c_dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL s1_idle: valid got %b want 0", c_dout_valid);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); a_in.val = arr_a; a_din_valid = 1; a_dout_ready = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); a_din_valid = 0;
    end
    @(negedge clk); #1;
    checks++;
    if ({a_dout_valid, a_dout_idx, a_out.val} !== {1'b1, 2'd2, exp_a[2]}) begin
      errors++;
      $display("FAIL rstmid_pre: got %h want %h", {a_dout_valid, a_dout_idx, a_out.val}, {1'b1, 2'd2, exp_a[2]});
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({a_dout_valid, a_dout_last, a_din_ready, a_out.val} !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_async: got %h want 00", {a_dout_valid, a_dout_last, a_din_ready, a_out.val});
    end
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if ({a_din_ready, a_dout_valid} !== 2'b10) begin
      errors++;
      $display("FAIL rstmid_release: got %b want 10", {a_din_ready, a_dout_valid});
    end
    a_in.val = arr_b; a_din_valid = 1;
    @(negedge clk); a_din_valid = 0; #1;
    got  = {a_dout_valid, a_dout_idx, a_dout_last, a_out.val};
    want = {1'b1, 2'd0, 1'b0, exp_b[0]};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL rstmid_restart: got %h want %h", got, want);
    end
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (a_dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_drain: valid got %b want 0", a_dout_valid);
    end
  endtask

  initial begin
    a_in.val = '0; b_in.val = '0; c_in.val = '0;
    test_reset();
    test_requant_order();
    test_sat_wrap();
    test_backpressure();
    test_back_to_back();
    test_size1();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
